// File: rtl/warb_pkg.sv
// Shared definitions for the register-bank write arbiter: default widths,
// lock FSM state type and requester index constants.
package warb_pkg;

    localparam int ADDR_WIDTH     = 2;
    localparam int REGISTER_WIDTH = 4;

    localparam int REQ_ALU  = 0;
    localparam int REQ_LOAD = 1;
    localparam int REQ_IMM  = 2;
    localparam int REQ_DBG  = 3;

    typedef enum logic {
        LOCK_UNLOCKED = 1'b0,
        LOCK_LOCKED   = 1'b1
    } lock_state_t;

    // Successor of a requester index, wrapping at n.
    function automatic int wrap_inc(input int idx, input int n);
        return ((idx + 1) >= n) ? 0 : (idx + 1);
    endfunction

endpackage

// File: rtl/regfile_write_arbiter_rr_pick.sv
// Rotate-priority encoder: first set bit of valid_i at or after ptr_i, wrapping.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  valid_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    logic [IW-1:0] j_s;

    // Scan N positions starting from the pointer; the first valid one wins.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        j_s     = '0;
        for (int k = 0; k < N; k++) begin
            j_s = IW'((int'(ptr_i) + k) % N);
            if (!any_o && valid_i[j_s]) begin
                any_o        = 1'b1;
                grant_o[j_s] = 1'b1;
                idx_o        = j_s;
            end else begin
                any_o = any_o;
            end
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter for the register bank write port. Optional burst lock
// is compiled in with WARB_LOCK_EN.
module regfile_write_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int NUM_REGS       = 4,
    parameter int ADDR_WIDTH     = 2,
    parameter int REGISTER_WIDTH = 4,
    localparam int IDW           = $clog2(NUM_REQ)
) (
    input  logic                              clk_i,
    input  logic                              reset_i,
    input  logic                              hold_i,
    input  logic [NUM_REQ-1:0]                req_valid_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]     req_addr_i,
    input  logic [NUM_REQ*REGISTER_WIDTH-1:0] req_data_i,
`ifdef WARB_LOCK_EN
    input  logic [NUM_REQ-1:0]                lock_i,
`endif
    output logic [NUM_REQ-1:0]                req_ready_o,
    output logic [NUM_REGS-1:0]               write_en_o,
    output logic [REGISTER_WIDTH-1:0]         write_data_o,
    output logic [IDW-1:0]                    grant_id_o,
    output logic                              addr_err_o
);

    import warb_pkg::*;

    logic [IDW-1:0]            ptr_q;
    logic [NUM_REQ-1:0]        pick_valid_s;
    logic [NUM_REQ-1:0]        pick_grant_s;
    logic [IDW-1:0]            pick_idx_s;
    logic                      pick_any_s;
    logic                      xfer_s;
    logic [IDW-1:0]            winner_next_s;
    logic [ADDR_WIDTH-1:0]     sel_addr_s;
    logic [REGISTER_WIDTH-1:0] sel_data_s;
    logic [NUM_REGS-1:0]       dec_s;
    logic [NUM_REGS-1:0]       write_en_q;
    logic [REGISTER_WIDTH-1:0] write_data_q;
    logic [IDW-1:0]            grant_id_q;
    logic                      addr_err_q;

`ifdef WARB_LOCK_EN
    lock_state_t    state_q;
    logic [IDW-1:0] owner_q;
    logic [IDW-1:0] owner_next_s;

    // While locked only the owner may compete for the port.
    always_comb begin
        pick_valid_s = '0;
        if (state_q == LOCK_LOCKED) begin
            pick_valid_s[owner_q] = req_valid_i[owner_q];
        end else begin
            pick_valid_s = req_valid_i;
        end
    end

    assign owner_next_s = IDW'(wrap_inc(int'(owner_q), NUM_REQ));
`else
    assign pick_valid_s = req_valid_i;
`endif

    rr_pick #(
        .N  (NUM_REQ),
        .IW (IDW)
    ) u_pick (
        .valid_i (pick_valid_s),
        .ptr_i   (ptr_q),
        .grant_o (pick_grant_s),
        .idx_o   (pick_idx_s),
        .any_o   (pick_any_s)
    );

    assign req_ready_o   = hold_i ? '0 : pick_grant_s;
    assign xfer_s        = pick_any_s & ~hold_i;
    assign winner_next_s = IDW'(wrap_inc(int'(pick_idx_s), NUM_REQ));
    assign sel_addr_s    = req_addr_i[int'(pick_idx_s)*ADDR_WIDTH +: ADDR_WIDTH];
    assign sel_data_s    = req_data_i[int'(pick_idx_s)*REGISTER_WIDTH +: REGISTER_WIDTH];

    // Address decode; an address past the bank matches nothing.
    always_comb begin
        dec_s = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (sel_addr_s == ADDR_WIDTH'(r)) begin
                dec_s[r] = 1'b1;
            end else begin
                dec_s[r] = 1'b0;
            end
        end
    end

`ifdef WARB_LOCK_EN
    // Pointer and lock FSM; hold freezes both.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            ptr_q   <= '0;
            state_q <= LOCK_UNLOCKED;
            owner_q <= '0;
        end else if (!hold_i) begin
            case (state_q)
                LOCK_UNLOCKED: begin
                    if (xfer_s) begin
                        ptr_q <= winner_next_s;
                        if (lock_i[pick_idx_s]) begin
                            state_q <= LOCK_LOCKED;
                            owner_q <= pick_idx_s;
                        end
                    end
                end
                LOCK_LOCKED: begin
                    if ((xfer_s && !lock_i[owner_q]) || !req_valid_i[owner_q]) begin
                        state_q <= LOCK_UNLOCKED;
                        ptr_q   <= owner_next_s;
                    end
                end
                default: state_q <= LOCK_UNLOCKED;
            endcase
        end
    end
`else
    // Pointer advances past the winner of each transfer.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            ptr_q <= '0;
        end else if (xfer_s) begin
            ptr_q <= winner_next_s;
        end
    end
`endif

    // Output stage toward the register bank.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            write_en_q   <= '0;
            write_data_q <= '0;
            grant_id_q   <= '0;
            addr_err_q   <= 1'b0;
        end else begin
            addr_err_q <= xfer_s & ~(|dec_s);
            if (xfer_s) begin
                write_en_q   <= dec_s;
                write_data_q <= sel_data_s;
                grant_id_q   <= pick_idx_s;
            end else begin
                write_en_q <= '0;
            end
        end
    end

    assign write_en_o   = write_en_q;
    assign write_data_o = write_data_q;
    assign grant_id_o   = grant_id_q;
    assign addr_err_o   = addr_err_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: directed scenarios plus a
// randomized run against a round-robin reference model.
module tb_regfile_write_arbiter;

    localparam int N    = 4;
    localparam int REGS = 3;
    localparam int AW   = 2;
    localparam int DW   = 4;
    localparam int IDW  = 2;

    logic            clk = 1'b0;
    logic            reset_i = 1'b1;
    logic            hold_i = 1'b0;
    logic [N-1:0]    req_valid_i = '0;
    logic [N*AW-1:0] req_addr_i = '0;
    logic [N*DW-1:0] req_data_i = '0;
`ifdef WARB_LOCK_EN
    logic [N-1:0]    lock_i = '0;
`endif
    logic [N-1:0]    req_ready_o;
    logic [REGS-1:0] write_en_o;
    logic [DW-1:0]   write_data_o;
    logic [IDW-1:0]  grant_id_o;
    logic            addr_err_o;

    int checks = 0;
    int fails  = 0;

    // Reference model state
    int              m_ptr;
    logic [REGS-1:0] m_we;
    logic [DW-1:0]   m_wd;
    logic [IDW-1:0]  m_gid;
    logic            m_err;

    // Values observed by run_cycle
    logic [N-1:0]    obs_ready;
    logic [REGS-1:0] obs_we;
    logic [DW-1:0]   obs_wd;
    logic [IDW-1:0]  obs_gid;
    logic            obs_err;

    always #5 clk = ~clk;

    regfile_write_arbiter #(
        .NUM_REQ        (N),
        .NUM_REGS       (REGS),
        .ADDR_WIDTH     (AW),
        .REGISTER_WIDTH (DW)
    ) dut (
        .clk_i        (clk),
        .reset_i      (reset_i),
        .hold_i       (hold_i),
        .req_valid_i  (req_valid_i),
        .req_addr_i   (req_addr_i),
        .req_data_i   (req_data_i),
`ifdef WARB_LOCK_EN
        .lock_i       (lock_i),
`endif
        .req_ready_o  (req_ready_o),
        .write_en_o   (write_en_o),
        .write_data_o (write_data_o),
        .grant_id_o   (grant_id_o),
        .addr_err_o   (addr_err_o)
    );

    function automatic logic [N-1:0] onehot(input int w);
        return (w >= 0) ? (N'(1) << w) : '0;
    endfunction

    // Winner under round-robin: first valid index at or after ptr, modulo N.
    function automatic int pick(input logic [N-1:0] v, input logic h, input int p);
        if (h) return -1;
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    function automatic void apply_model(input int w);
        logic [AW-1:0] a;
        if (w >= 0) begin
            a     = req_addr_i[w*AW +: AW];
            m_we  = (int'(a) < REGS) ? (REGS'(1) << a) : '0;
            m_err = (int'(a) >= REGS);
            m_wd  = req_data_i[w*DW +: DW];
            m_gid = IDW'(w);
            m_ptr = (w + 1) % N;
        end else begin
            m_we  = '0;
            m_err = 1'b0;
        end
    endfunction

    function automatic void model_reset();
        m_ptr = 0; m_we = '0; m_wd = '0; m_gid = '0; m_err = 1'b0;
    endfunction

    // Drive one cycle from a negedge, capture ready and registered outputs.
    task automatic run_cycle(input logic [N-1:0] v, input logic h, output int w);
        req_valid_i = v;
        hold_i      = h;
        #1;
        w         = pick(v, h, m_ptr);
        obs_ready = req_ready_o;
        @(posedge clk);
        apply_model(w);
        #1;
        obs_we  = write_en_o;
        obs_wd  = write_data_o;
        obs_gid = grant_id_o;
        obs_err = addr_err_o;
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset_i     = 1'b1;
        req_valid_i = '0;
        hold_i      = 1'b0;
`ifdef WARB_LOCK_EN
        lock_i      = '0;
`endif
        @(negedge clk);
        @(negedge clk);
        reset_i = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({write_en_o, write_data_o, grant_id_o, addr_err_o} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got we=%b wd=%h gid=%0d err=%b, expected all zero",
                     write_en_o, write_data_o, grant_id_o, addr_err_o);
        end
    endtask

    task automatic test_single();
        int w;
        do_reset();
        req_addr_i[0*AW +: AW] = 2'd2;
        req_data_i[0*DW +: DW] = 4'hA;
        run_cycle(4'b0001, 1'b0, w);
        checks++;
        if (obs_ready !== 4'b0001) begin
            fails++; $display("FAIL single_ready: got %b expected 0001", obs_ready);
        end
        checks++;
        if ({obs_we, obs_wd, obs_gid, obs_err} !== {3'b100, 4'hA, 2'd0, 1'b0}) begin
            fails++;
            $display("FAIL single_write: got we=%b wd=%h gid=%0d err=%b expected we=100 wd=a gid=0 err=0",
                     obs_we, obs_wd, obs_gid, obs_err);
        end
    endtask

    task automatic test_round_robin();
        int w;
        do_reset();
        for (int i = 0; i < N; i++) begin
            req_addr_i[i*AW +: AW] = AW'(i % REGS);
            req_data_i[i*DW +: DW] = DW'(i + 5);
        end
        for (int c = 0; c < N + 1; c++) begin
            run_cycle(4'b1111, 1'b0, w);
            checks++;
            if (obs_ready !== onehot(c % N) || obs_gid !== IDW'(c % N)) begin
                fails++;
                $display("FAIL rr_order cycle %0d: got ready=%b gid=%0d expected ready=%b gid=%0d",
                         c, obs_ready, obs_gid, onehot(c % N), c % N);
            end
        end
    endtask

    task automatic test_hold();
        int w;
        do_reset();
        for (int i = 0; i < N; i++) begin
            req_addr_i[i*AW +: AW] = 2'd1;
            req_data_i[i*DW +: DW] = DW'(i + 1);
        end
        for (int c = 0; c < 3; c++) begin
            run_cycle(4'b1010, 1'b1, w);
            checks++;
            if (obs_ready !== 4'b0000 || obs_we !== 3'b000 || obs_gid !== 2'd0) begin
                fails++;
                $display("FAIL hold_block cycle %0d: got ready=%b we=%b gid=%0d expected 0000 000 0",
                         c, obs_ready, obs_we, obs_gid);
            end
        end
        run_cycle(4'b1010, 1'b0, w);
        checks++;
        if (obs_ready !== 4'b0010 || obs_gid !== 2'd1 || obs_wd !== 4'h2) begin
            fails++;
            $display("FAIL hold_release1: got ready=%b gid=%0d wd=%h expected 0010 1 2", obs_ready, obs_gid, obs_wd);
        end
        run_cycle(4'b1010, 1'b0, w);
        checks++;
        if (obs_ready !== 4'b1000 || obs_gid !== 2'd3) begin
            fails++;
            $display("FAIL hold_release2: got ready=%b gid=%0d expected 1000 3", obs_ready, obs_gid);
        end
        run_cycle(4'b0000, 1'b0, w);
        checks++;
        if (obs_we !== 3'b000 || obs_wd !== 4'h4 || obs_gid !== 2'd3) begin
            fails++;
            $display("FAIL idle_hold_values: got we=%b wd=%h gid=%0d expected 000 4 3", obs_we, obs_wd, obs_gid);
        end
    endtask

    task automatic test_addr_err();
        int w;
        do_reset();
        req_addr_i[2*AW +: AW] = 2'd3;
        req_data_i[2*DW +: DW] = 4'h7;
        req_addr_i[3*AW +: AW] = 2'd0;
        req_data_i[3*DW +: DW] = 4'h9;
        run_cycle(4'b0100, 1'b0, w);
        checks++;
        if ({obs_ready, obs_we, obs_err, obs_gid} !== {4'b0100, 3'b000, 1'b1, 2'd2}) begin
            fails++;
            $display("FAIL addr_err: got ready=%b we=%b err=%b gid=%0d expected 0100 000 1 2",
                     obs_ready, obs_we, obs_err, obs_gid);
        end
        run_cycle(4'b1001, 1'b0, w);
        checks++;
        if ({obs_ready, obs_we, obs_err} !== {4'b1000, 3'b001, 1'b0}) begin
            fails++;
            $display("FAIL addr_err_after: got ready=%b we=%b err=%b expected 1000 001 0",
                     obs_ready, obs_we, obs_err);
        end
    endtask

    task automatic test_reset_mid();
        int w;
        do_reset();
        req_addr_i[0*AW +: AW] = 2'd1;
        req_data_i[0*DW +: DW] = 4'hC;
        req_valid_i = 4'b0001;
        @(posedge clk);
        #1;
        checks++;
        if (write_en_o !== 3'b010 || write_data_o !== 4'hC) begin
            fails++;
            $display("FAIL mid_accept: got we=%b wd=%h expected 010 c", write_en_o, write_data_o);
        end
        reset_i = 1'b1;
        #1;
        checks++;
        if (write_en_o !== 3'b000 || write_data_o !== 4'h0) begin
            fails++;
            $display("FAIL mid_reset_clear: got we=%b wd=%h expected 000 0", write_en_o, write_data_o);
        end
        @(negedge clk);
        reset_i = 1'b0;
        model_reset();
        run_cycle(4'b0011, 1'b0, w);
        checks++;
        if (obs_ready !== 4'b0001) begin
            fails++; $display("FAIL mid_reset_ptr: got ready=%b expected 0001", obs_ready);
        end
    endtask

`ifdef WARB_LOCK_EN
    task automatic test_lock();
        int w;
        do_reset();
        req_addr_i = '0;
        run_cycle(4'b0001, 1'b0, w);
        lock_i = 4'b0010;
        for (int c = 0; c < 3; c++) begin
            run_cycle(4'b0011, 1'b0, w);
            checks++;
            if (obs_ready !== 4'b0010) begin
                fails++; $display("FAIL lock_owner cycle %0d: got ready=%b expected 0010", c, obs_ready);
            end
        end
        lock_i = 4'b0000;
        run_cycle(4'b0011, 1'b0, w);
        checks++;
        if (obs_ready !== 4'b0010) begin
            fails++; $display("FAIL lock_release: got ready=%b expected 0010", obs_ready);
        end
        run_cycle(4'b0011, 1'b0, w);
        checks++;
        if (obs_ready !== 4'b0001) begin
            fails++; $display("FAIL lock_after: got ready=%b expected 0001", obs_ready);
        end
    endtask
`endif

    task automatic test_random();
        int w;
        do_reset();
        for (int c = 0; c < 300; c++) begin
            req_addr_i = (N*AW)'($urandom());
            req_data_i = (N*DW)'($urandom());
            run_cycle(N'($urandom()), ($urandom_range(0, 3) == 0), w);
            checks++;
            if (obs_ready !== onehot(w)) begin
                fails++; $display("FAIL rand_ready cycle %0d: got %b expected %b", c, obs_ready, onehot(w));
            end
            checks++;
            if ({obs_we, obs_wd, obs_gid, obs_err} !== {m_we, m_wd, m_gid, m_err}) begin
                fails++;
                $display("FAIL rand_write cycle %0d: got we=%b wd=%h gid=%0d err=%b expected we=%b wd=%h gid=%0d err=%b",
                         c, obs_we, obs_wd, obs_gid, obs_err, m_we, m_wd, m_gid, m_err);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_round_robin();
        test_hold();
        test_addr_err();
        test_reset_mid();
`ifdef WARB_LOCK_EN
        test_lock();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Round-robin arbiter that shares the single write port of the CPU register bank among several requesters (ALU result, load unit, immediate path, debug port). It accepts at most one write per cycle through a valid/ready handshake and drives registered, one-hot write enables plus a shared data bus into the bank of `my_register` instances. It sits between the execute-stage producers and the register bank.

## Interface
Parameters:
- `NUM_REQ`, 4, number of requesters (2..8)
- `NUM_REGS`, 4, registers in the bank
- `ADDR_WIDTH`, 2, register address width; must satisfy 2^ADDR_WIDTH >= NUM_REGS
- `REGISTER_WIDTH`, 4, data width

Ports:
- `clk_i`  in  1  clock, rising edge
- `reset_i`  in  1  asynchronous, active-high reset
- `hold_i`  in  1  CPU stall; no grants while high
- `req_valid_i`  in  NUM_REQ  per-requester write request
- `req_addr_i`  in  NUM_REQ*ADDR_WIDTH  packed target addresses; requester i at slice i
- `req_data_i`  in  NUM_REQ*REGISTER_WIDTH  packed write data
- `req_ready_o`  out  NUM_REQ  one-hot grant; a transfer occurs when valid & ready
- `write_en_o`  out  NUM_REGS  one-hot enable to register bank
- `write_data_o`  out  REGISTER_WIDTH  data to register bank
- `grant_id_o`  out  $clog2(NUM_REQ)  index of requester whose write is on `write_*_o`
- `addr_err_o`  out  1  one-cycle pulse: accepted address >= NUM_REGS
- `lock_i`  in  NUM_REQ  burst lock; present only with `WARB_LOCK_EN`

## Operation
- Round-robin pointer `rr_ptr`. Search starts at `rr_ptr` and wraps modulo NUM_REQ; the first valid requester wins.
- After each transfer, `rr_ptr` becomes winner+1, wrapping from NUM_REQ-1 to 0. With no transfer, `rr_ptr` holds.
- `req_ready_o` is combinational from `req_valid_i`, `rr_ptr` and `hold_i`. It is at most one-hot, and a bit is never set without its valid.
- `hold_i`=1 forces `req_ready_o`=0 and leaves `rr_ptr` unchanged.
- On a transfer, the output stage registers:
  - `write_en_o` = decode(addr)
  - `write_data_o` = data
  - `grant_id_o` = winner
- With no transfer, `write_en_o`=0; `write_data_o` and `grant_id_o` hold their values.
- Out-of-range address (addr >= NUM_REGS):
  - the transfer is accepted and the pointer advances;
  - `write_en_o`=0 and `addr_err_o`=1 for that cycle.
- Requesters must hold valid/addr/data stable until ready; the arbiter does not check this.

## Timing
- Grant is issued in the same cycle as valid when the requester is selected: zero-cycle accept.
- `write_en_o` is asserted in the cycle after acceptance. The register captures at the following edge, so the new value appears on `out_o` two edges after the accept edge.
- Throughput: one write per cycle; back-to-back grants to different requesters are allowed.
- Reset values:
  - `rr_ptr`=0, `write_en_o`=0, `write_data_o`=0, `grant_id_o`=0, `addr_err_o`=0
  - lock state = UNLOCKED
- Reset asserted mid-operation clears all state immediately. An accepted but not yet written transfer is dropped.
- Reset released: the first grant is possible in the same cycle; requester 0 has priority.

## Configuration
- `WARB_LOCK_EN` defined: adds the `lock_i` port and a two-state FSM, UNLOCKED / LOCKED(owner).
  - UNLOCKED -> LOCKED when a transfer occurs with `lock_i[winner]`=1.
  - In LOCKED, only the owner can be granted and `rr_ptr` does not advance.
  - LOCKED -> UNLOCKED on an owner transfer with `lock_i[owner]`=0, or when `req_valid_i[owner]`=0; then `rr_ptr` = owner+1.
  - `hold_i` freezes the FSM.
- `WARB_LOCK_EN` undefined: no `lock_i` port, no FSM, pure round-robin.

## Structure
- Shared package `warb_pkg`:
  - default widths (`ADDR_WIDTH`, `REGISTER_WIDTH`)
  - lock state enum `lock_state_t`
  - requester index constants (`REQ_ALU`=0, `REQ_LOAD`=1, `REQ_IMM`=2, `REQ_DBG`=3)
- Sub-module `rr_pick`: combinational rotate-priority encoder. Inputs: valid vector and pointer. Outputs: one-hot grant and index.

## Test plan
- Reset, then valid=4'b0001, addr=2, data=4'hA -> ready[0] same cycle; next cycle `write_en_o`=4'b0100, `write_data_o`=4'hA, `grant_id_o`=0.
- Valid=4'b1111 held for 4 cycles -> grants 0,1,2,3 in order; then `rr_ptr` wraps to 0.
- Valid=4'b1010 with `hold_i`=1 for 3 cycles -> no ready, `write_en_o`=0; hold drops -> grant 1, then 3.
- Requester 2 writes addr=3 with NUM_REGS=3 -> accepted, `write_en_o`=0, `addr_err_o` pulses 1 cycle, pointer advances to 3.
- Assert `reset_i` in the cycle after an accept -> `write_en_o` goes 0 immediately, the write is lost, `rr_ptr`=0.
- `WARB_LOCK_EN`: req 1 with lock=1 for 3 transfers while req 0 is valid -> req 0 is blocked; req 1 clears lock -> req 0 is granted after the pointer moves to 2 and wraps.
